// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter: default parameters and FSM state encoding.
package mem_pkg;
  localparam int DATA_W_DEF  = 8;
  localparam int ADDR_W_DEF  = 8;
  localparam int DEPTH_DEF   = 256;
  localparam int WAIT_ST_DEF = 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    INS_WAIT = 2'd1,
    DAT_WAIT = 2'd2,
    DONE     = 2'd3
  } state_t;
endpackage

// File: rtl/mem_array.sv
// Single-port storage: synchronous write, combinational read (zero beyond DEPTH).
module mem_array
  import mem_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
)(
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = (32'(addr) < 32'(DEPTH)) ? mem[addr] : '0;
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction port and a data port onto one shared array with
// WAIT_ST wait cycles per access; grant-to-ack latency is WAIT_ST+2 cycles.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int WAIT_ST = WAIT_ST_DEF
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              ins_req,
  input  logic [ADDR_W-1:0] ins_addr,
  output logic [DATA_W-1:0] ins_data,
  output logic              ins_ack,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              busy
);
  localparam int MAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic              prio_dat;
  logic              cur_dat;
  logic              cur_write;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [DATA_W-1:0] arr_rdata;
  logic [DATA_W-1:0] rd_word;
  logic              dat_req, grant_dat, grant_ins, in_range, we;

  // prio_dat is set after an instruction grant, so contention alternates;
  // out of reset the instruction port goes first.
  assign dat_req   = d_read | d_write;
  assign grant_dat = dat_req & (~ins_req | prio_dat);
  assign grant_ins = ins_req & ~grant_dat;
  assign in_range  = 32'(cur_addr) < 32'(DEPTH);
  assign rd_word   = in_range ? arr_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (grant_dat)      state_nxt = DAT_WAIT;
        else if (grant_ins) state_nxt = INS_WAIT;
      end
      INS_WAIT, DAT_WAIT: if (cnt == 4'd0) state_nxt = DONE;
      DONE:               state_nxt = IDLE;
      default:            state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    we   = (state == DONE) && cur_write && in_range;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      prio_dat  <= 1'b0;
      cur_dat   <= 1'b0;
      cur_write <= 1'b0;
      cur_addr  <= '0;
      cur_wdata <= '0;
      ins_ack   <= 1'b0;
      d_ack     <= 1'b0;
      ins_data  <= '0;
      d_rdata   <= '0;
    end else begin
      ins_ack <= 1'b0;
      d_ack   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_dat || grant_ins) begin
            cur_dat   <= grant_dat;
            cur_write <= grant_dat & d_write;
            cur_addr  <= grant_dat ? d_addr : ins_addr;
            cur_wdata <= d_wdata;
            cnt       <= 4'(WAIT_ST);
            prio_dat  <= grant_ins;
          end
        end
        INS_WAIT, DAT_WAIT: if (cnt != 4'd0) cnt <= cnt - 4'd1;
        DONE: begin
          if (cur_dat) begin
            d_ack <= 1'b1;
            if (!cur_write) d_rdata <= rd_word;
          end else begin
            ins_ack  <= 1'b1;
            ins_data <= rd_word;
          end
        end
        default: ;
      endcase
    end
  end

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .addr  (cur_addr[MAW-1:0]),
    .wdata (cur_wdata),
    .rdata (arr_rdata)
  );
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: main instance (DEPTH=200, WAIT_ST=1) plus a zero-wait instance.
module tb_mem_arbiter;
  localparam int W_MAIN = 1;
  localparam int DEP    = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ins_req = 1'b0, d_read = 1'b0, d_write = 1'b0;
  logic [7:0] ins_addr = '0, d_addr = '0, d_wdata = '0;
  logic [7:0] ins_data, d_rdata;
  logic       ins_ack, d_ack, busy;

  logic       z_ins_req = 1'b0, z_d_read = 1'b0, z_d_write = 1'b0;
  logic [7:0] z_ins_addr = '0, z_d_addr = '0, z_d_wdata = '0;
  logic [7:0] z_ins_data, z_d_rdata;
  logic       z_ins_ack, z_d_ack, z_busy;

  typedef struct packed { logic port; logic [7:0] data; } exp_t;
  exp_t       sb[$];
  logic [7:0] model [256];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_W(8), .ADDR_W(8), .DEPTH(DEP), .WAIT_ST(W_MAIN)) u_dut (
    .clk(clk), .rst(rst),
    .ins_req(ins_req), .ins_addr(ins_addr), .ins_data(ins_data), .ins_ack(ins_ack),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .busy(busy)
  );

  mem_arbiter #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .WAIT_ST(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .ins_req(z_ins_req), .ins_addr(z_ins_addr), .ins_data(z_ins_data), .ins_ack(z_ins_ack),
    .d_read(z_d_read), .d_write(z_d_write), .d_addr(z_d_addr), .d_wdata(z_d_wdata),
    .d_rdata(z_d_rdata), .d_ack(z_d_ack), .busy(z_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One data-port access on the main instance; requests are driven at a negedge while idle.
  task automatic d_op(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] wd);
    int   n;
    logic seen;
    exp_t e;
    d_read = rd; d_write = wr; d_addr = a; d_wdata = wd;
    if (wr) begin
      if (a < 8'(DEP)) model[a] = wd;
    end else begin
      sb.push_back('{1'b1, (a < 8'(DEP)) ? model[a] : 8'h00});
    end
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) chk("busy_after_grant", busy, 1);
      seen = d_ack;
    end
    d_read = 1'b0; d_write = 1'b0;
    chk("d_ack_seen", seen, 1);
    if (seen) begin
      chk("d_latency", n - 1, W_MAIN + 2);
      if (!wr) begin
        e = sb.pop_front();
        chk("d_rdata", d_rdata, e.data);
      end
    end
    @(negedge clk);
    chk("d_ack_one_pulse", d_ack, 0);
  endtask

  // Waits for an ack on the zero-wait instance and reports grant-to-ack cycles.
  task automatic z_wait(input logic ins, output int n, output logic seen);
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      seen = ins ? z_ins_ack : z_d_ack;
    end
  endtask

  initial begin
    int   n, acks;
    logic seen;
    exp_t e;

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ins_ack", ins_ack, 0);
    chk("rst_d_ack", d_ack, 0);
    chk("rst_ins_data", ins_data, 0);
    chk("rst_d_rdata", d_rdata, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // write then read back
    d_op(1'b0, 1'b1, 8'h10, 8'hA5);
    d_op(1'b1, 1'b0, 8'h10, 8'h00);

    // read and write together behave as a write
    d_op(1'b1, 1'b1, 8'h20, 8'h77);
    d_op(1'b1, 1'b0, 8'h20, 8'h00);

    // out of range: write discarded, read zero, neighbours untouched
    d_op(1'b0, 1'b1, 8'h48, 8'h11);
    d_op(1'b0, 1'b1, 8'h00, 8'h22);
    d_op(1'b0, 1'b1, 8'hC8, 8'hFF);
    d_op(1'b1, 1'b0, 8'hC8, 8'h00);
    d_op(1'b1, 1'b0, 8'h48, 8'h00);
    d_op(1'b1, 1'b0, 8'h00, 8'h00);

    // reset during the wait phase of a write
    d_op(1'b0, 1'b1, 8'h05, 8'h5A);
    d_write = 1'b1; d_addr = 8'h05; d_wdata = 8'h3C;
    @(negedge clk);
    chk("midop_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("midop_busy_reset", busy, 0);
    d_write = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("midop_no_ack", d_ack, 0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("midop_still_no_ack", d_ack, 0);
    d_op(1'b1, 1'b0, 8'h05, 8'h00);

    // contention straight after reset: instruction first, then alternating
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    sb.push_back('{1'b0, model[8'h10]});
    sb.push_back('{1'b1, model[8'h20]});
    sb.push_back('{1'b0, model[8'h10]});
    sb.push_back('{1'b1, model[8'h20]});
    ins_req = 1'b1; ins_addr = 8'h10;
    d_read  = 1'b1; d_addr   = 8'h20;
    acks = 0; n = 0;
    while (acks < 4 && n < 60) begin
      @(negedge clk);
      n++;
      if (ins_ack || d_ack) begin
        acks++;
        e = sb.pop_front();
        chk("cont_one_ack", {31'd0, ins_ack & d_ack}, 0);
        chk("cont_port", d_ack, e.port);
        chk("cont_data", e.port ? d_rdata : ins_data, e.data);
      end
    end
    ins_req = 1'b0; d_read = 1'b0;
    chk("cont_ack_count", acks, 4);
    sb.delete();
    repeat (2) @(negedge clk);

    // zero wait states on the second instance
    z_d_write = 1'b1; z_d_addr = 8'h00; z_d_wdata = 8'h3E;
    z_wait(1'b0, n, seen);
    z_d_write = 1'b0;
    chk("z_d_ack_seen", seen, 1);
    chk("z_d_latency", n - 1, 2);
    @(negedge clk);
    z_ins_req = 1'b1; z_ins_addr = 8'h00;
    z_wait(1'b1, n, seen);
    z_ins_req = 1'b0;
    chk("z_ins_ack_seen", seen, 1);
    chk("z_ins_latency", n - 1, 2);
    chk("z_ins_data", z_ins_data, 8'h3E);
    @(negedge clk);
    chk("z_ins_ack_pulse", z_ins_ack, 0);
    chk("z_ins_data_hold", z_ins_data, 8'h3E);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the data word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 8, meaning the address width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 256, meaning the number of storage words (DEPTH <= 2**ADDR_W).
REQ-004 The block SHALL have parameter WAIT_ST, default 1, range 0..15, meaning the wait cycles inserted per access.
REQ-005 The block SHALL have one clock and an asynchronous active-high reset: clk  in  1  rising-edge clock; rst  in  1  asynchronous reset, active high.
REQ-006 The block SHALL have these ports:
- ins_req  in  1  instruction fetch request.
- ins_addr  in  ADDR_W  fetch address.
- ins_data  out  DATA_W  fetched word.
- ins_ack  out  1  fetch done; one-cycle pulse.
- d_read  in  1  data read request.
- d_write  in  1  data write request.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_rdata  out  DATA_W  read data.
- d_ack  out  1  data access done; one-cycle pulse.
- busy  out  1  access in progress.

Function
REQ-007 Storage SHALL be a single-port array of DEPTH x DATA_W words, shared by both requesters.
REQ-008 The FSM SHALL have states IDLE, INS_WAIT, DAT_WAIT and DONE.
REQ-009 In IDLE with no request pending, the FSM SHALL stay in IDLE with busy=0.
REQ-010 Arbitration when both ports request in IDLE SHALL follow a last-grant flag:
- data wins if the previous grant was instruction;
- instruction wins otherwise;
- the flag resets to "instruction".
REQ-011 On grant, the block SHALL latch the address, direction and write data, then load the wait counter with WAIT_ST.
REQ-012 Requesters SHALL hold their request and operands stable until their ack, and inputs changing after the grant SHALL have no effect on the current access.
REQ-013 In INS_WAIT or DAT_WAIT, the counter SHALL decrement each cycle, and the FSM SHALL move to DONE when the counter is 0; WAIT_ST=0 SHALL enter DONE the cycle after the grant.
REQ-014 In DONE, the block SHALL perform the array access and pulse the matching ack for exactly one cycle:
- the read data SHALL appear on ins_data/d_rdata in the same cycle as the ack;
- a write SHALL update the array at that clock edge.
REQ-015 The latency from grant to ack SHALL be WAIT_ST+2 cycles when uncontended; DONE SHALL return to IDLE, and back-to-back accesses SHALL be separated by one IDLE cycle.
REQ-016 d_read and d_write both high SHALL be treated as a write.
REQ-017 For an address >= DEPTH, a read SHALL return all-zeros, a write SHALL be discarded, and the ack SHALL still be issued.
REQ-018 ins_data and d_rdata SHALL hold their last value until the next ack on the same port.
REQ-019 busy SHALL be 1 in INS_WAIT, DAT_WAIT and DONE.

Reset
REQ-020 On rst, the block SHALL force state IDLE, counter 0, last-grant "instruction", ins_ack=0, d_ack=0, busy=0, ins_data=0 and d_rdata=0.
REQ-021 Reset mid-access SHALL abort the access with no ack and no array write, and array contents SHALL NOT be reset.

Structure
REQ-022 The FSM state encoding and the default parameter values SHALL live in the shared package mem_pkg.
REQ-023 The storage array SHALL be the sub-module mem_array (parameters DATA_W and DEPTH; ports clk, we, addr, wdata, rdata; synchronous write, combinational read) instantiated once.
REQ-024 The arbiter FSM and wait counter SHALL be in mem_arbiter itself.

Verification
REQ-025 The bench SHALL cover a write then a read: WAIT_ST=1, d_write addr 0x10 data 0xA5, then d_read addr 0x10 -> d_ack 3 cycles after each grant, d_rdata=0xA5.
REQ-026 The bench SHALL cover contention: ins_req and d_read asserted together after reset -> instruction acked first, data acked next, then alternating while both remain asserted.
REQ-027 The bench SHALL cover out of range: DEPTH=200, write 0xFF to addr 0xC8, then read it -> d_ack pulses, d_rdata=0x00, and addr 0xC8 is unchanged internally.
REQ-028 The bench SHALL cover zero wait: WAIT_ST=0, ins_req addr 0x00 -> ins_ack exactly 2 cycles after the grant.
REQ-029 The bench SHALL cover reset mid-operation: rst asserted during DAT_WAIT of a write 0x3C to addr 0x05 -> no d_ack, busy=0 immediately, and a later read of addr 0x05 returns the prior value.
REQ-030 The bench SHALL cover simultaneous read and write: d_read=d_write=1 at addr 0x20 with data 0x77 -> a write is performed, and a subsequent read returns 0x77.
